// File: rtl/axi_slv_mem.sv
// axi_slv_mem: AXI4 slave backed by a MEM_DEPTH x DATA_WIDTH word memory.
// Independent write (AW/W/B) and read (AR/R) engines supporting FIXED, INCR
// and WRAP bursts, per-lane byte strobes and SLVERR reporting.
// Ports:
//   ACLK, ARESETn             clock, asynchronous active-low reset
//   AW*  / AWREADY            write address channel
//   W*   / WREADY             write data channel
//   B*   / BREADY             write response channel
//   AR*  / ARREADY            read address channel
//   R*   / RREADY             read data channel
module axi_slv_mem #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [ID_WIDTH-1:0]     RID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(NBYTES);
  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [2:0]          MAX_SIZE = 3'(LSB);
  localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH+1)'(MEM_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  function automatic logic f_wrap_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Errors that apply to every beat of a burst regardless of address.
  function automatic logic f_burst_err(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
    return (size > MAX_SIZE) || (burst == 2'd3) || ((burst == 2'd2) && !f_wrap_ok(len));
  endfunction

  function automatic logic f_oob(input logic [ADDR_WIDTH-1:0] addr);
    return {1'b0, (addr >> LSB)} >= DEPTH_L;
  endfunction

  function automatic logic [IDX_W-1:0] f_idx(input logic [ADDR_WIDTH-1:0] addr);
    return IDX_W'(addr >> LSB);
  endfunction

  // Illegal WRAP lengths and the reserved type fall back to plain increment.
  function automatic logic [ADDR_WIDTH-1:0] f_next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [7:0] len,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] mask;
    logic [ADDR_WIDTH-1:0] res;
    incr = ADDR_WIDTH'(1) << size;
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    res  = addr + incr;
    if (burst == 2'd0)
      res = addr;
    else if ((burst == 2'd2) && f_wrap_ok(len))
      res = (addr & ~mask) | ((addr + incr) & mask);
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  wstate_t r_wstate, w_wstate_nx;
  rstate_t r_rstate, w_rstate_nx;
  logic    r_alive;

  logic [ID_WIDTH-1:0]   r_awid;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [7:0]            r_awlen, r_wcnt;
  logic [2:0]            r_awsize;
  logic [1:0]            r_awburst, r_bresp;
  logic                  r_werr;

  logic [ID_WIDTH-1:0]   r_arid;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [7:0]            r_arlen, r_rcnt;
  logic [2:0]            r_arsize;
  logic [1:0]            r_arburst, r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rlast;

  logic                  w_whs, w_wlast_beat, w_wout, w_wbeat_err;
  logic                  w_arhs, w_rhs, w_ar_err, w_rn_err;
  logic [ADDR_WIDTH-1:0] w_rnext_addr;

  assign w_whs        = WVALID && WREADY;
  assign w_wlast_beat = (r_wcnt == r_awlen);
  assign w_wout       = f_oob(r_waddr);
  assign w_wbeat_err  = f_burst_err(r_awlen, r_awsize, r_awburst) || w_wout ||
                        (WLAST != w_wlast_beat);

  assign w_arhs       = ARVALID && ARREADY;
  assign w_rhs        = RVALID && RREADY;
  assign w_ar_err     = f_burst_err(ARLEN, ARSIZE, ARBURST) || f_oob(ARADDR);
  assign w_rnext_addr = f_next_addr(r_raddr, r_arlen, r_arsize, r_arburst);
  assign w_rn_err     = f_burst_err(r_arlen, r_arsize, r_arburst) || f_oob(w_rnext_addr);

  assign BID   = r_awid;
  assign BRESP = r_bresp;
  assign RID   = r_arid;
  assign RDATA = r_rdata;
  assign RRESP = r_rresp;
  assign RLAST = r_rlast;

  // Holds both address READYs low until the first edge after reset release.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_alive <= 1'b0;
    else          r_alive <= 1'b1;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wstate_nx;
      r_rstate <= w_rstate_nx;
    end
  end

  always_comb begin
    w_wstate_nx = r_wstate;
    AWREADY     = 1'b0;
    WREADY      = 1'b0;
    BVALID      = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        AWREADY = r_alive;
        if (AWVALID && r_alive) w_wstate_nx = W_DATA;
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID && w_wlast_beat) w_wstate_nx = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) w_wstate_nx = W_IDLE;
      end
      default: w_wstate_nx = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_nx = r_rstate;
    ARREADY     = 1'b0;
    RVALID      = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        ARREADY = r_alive;
        if (ARVALID && r_alive) w_rstate_nx = R_DATA;
      end
      R_DATA: begin
        RVALID = 1'b1;
        if (RREADY && (r_rcnt == r_arlen)) w_rstate_nx = R_IDLE;
      end
      default: w_rstate_nx = R_IDLE;
    endcase
  end

  // Write address/beat tracking; the error flag accumulates across the burst.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_awid    <= '0;
      r_waddr   <= '0;
      r_awlen   <= '0;
      r_awsize  <= '0;
      r_awburst <= '0;
      r_wcnt    <= '0;
      r_werr    <= 1'b0;
      r_bresp   <= '0;
    end else begin
      if (AWVALID && AWREADY) begin
        r_awid    <= AWID;
        r_waddr   <= AWADDR;
        r_awlen   <= AWLEN;
        r_awsize  <= AWSIZE;
        r_awburst <= AWBURST;
        r_wcnt    <= '0;
        r_werr    <= 1'b0;
      end
      if (w_whs) begin
        r_waddr <= f_next_addr(r_waddr, r_awlen, r_awsize, r_awburst);
        r_wcnt  <= r_wcnt + 8'd1;
        r_werr  <= r_werr || w_wbeat_err;
        if (w_wlast_beat) r_bresp <= (r_werr || w_wbeat_err) ? 2'b10 : 2'b00;
      end
    end
  end

  // Storage is never reset; out-of-range beats are dropped.
  always_ff @(posedge ACLK) begin
    if (w_whs && !w_wout) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (WSTRB[b]) r_mem[f_idx(r_waddr)][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  // Read data is registered one word ahead; a same-cycle write is not visible.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_arid    <= '0;
      r_raddr   <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= '0;
      r_rcnt    <= '0;
      r_rdata   <= '0;
      r_rresp   <= '0;
      r_rlast   <= 1'b0;
    end else if (w_arhs) begin
      r_arid    <= ARID;
      r_raddr   <= ARADDR;
      r_arlen   <= ARLEN;
      r_arsize  <= ARSIZE;
      r_arburst <= ARBURST;
      r_rcnt    <= '0;
      r_rlast   <= (ARLEN == 8'd0);
      r_rdata   <= w_ar_err ? '0 : r_mem[f_idx(ARADDR)];
      r_rresp   <= w_ar_err ? 2'b10 : 2'b00;
    end else if (w_rhs) begin
      if (r_rcnt == r_arlen) begin
        r_rlast <= 1'b0;
      end else begin
        r_raddr <= w_rnext_addr;
        r_rcnt  <= r_rcnt + 8'd1;
        r_rlast <= ((r_rcnt + 8'd1) == r_arlen);
        r_rdata <= w_rn_err ? '0 : r_mem[f_idx(w_rnext_addr)];
        r_rresp <= w_rn_err ? 2'b10 : 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_axi_slv_mem.sv
// tb_axi_slv_mem: directed bench for axi_slv_mem with a word-array reference
// model, expected-response queues and one per-cycle compare process.
module tb_axi_slv_mem;
  localparam int DEPTH = 256;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [3:0]  AWID = '0, BID, ARID = '0, RID;
  logic [15:0] AWADDR = '0, ARADDR = '0;
  logic [7:0]  AWLEN = '0, ARLEN = '0;
  logic [2:0]  AWSIZE = '0, ARSIZE = '0;
  logic [1:0]  AWBURST = '0, ARBURST = '0, BRESP, RRESP;
  logic        AWVALID = 1'b0, AWREADY, WLAST = 1'b0, WVALID = 1'b0, WREADY;
  logic [31:0] WDATA = '0, RDATA;
  logic [3:0]  WSTRB = '0;
  logic        BVALID, BREADY = 1'b1, ARVALID = 1'b0, ARREADY;
  logic        RLAST, RVALID, RREADY = 1'b1;

  axi_slv_mem dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model
  logic [31:0] mdl [DEPTH];
  typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rexp_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;
  rexp_t rq[$];
  bexp_t bq[$];

  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] rcap [16];
  logic [1:0]  bcap;

  function automatic bit wrap_ok(input int len);
    return (len == 1) || (len == 3) || (len == 7) || (len == 15);
  endfunction

  function automatic bit burst_err(input int len, input int size, input int burst);
    return (size > 2) || (burst == 3) || (burst == 2 && !wrap_ok(len));
  endfunction

  function automatic bit oob(input logic [15:0] a);
    return (int'(a) / 4) >= DEPTH;
  endfunction

  // Byte address of beat i, straight from the burst-type definitions.
  function automatic logic [15:0] beat_addr(input logic [15:0] start, input int len,
                                            input int size, input int burst, input int i);
    int step, wb, s, base;
    step = 1 << size;
    s    = int'(start);
    if (burst == 0) return start;
    if (burst == 2 && wrap_ok(len)) begin
      wb   = (len + 1) * step;
      base = (s / wb) * wb;
      return 16'(base + ((s - base + i * step) % wb));
    end
    return 16'(s + i * step);
  endfunction

  // Compare process
  logic        held_v = 1'b0;
  logic [31:0] h_data;
  logic [1:0]  h_resp;
  logic        h_last;

  always @(negedge ACLK) begin
    rexp_t re;
    bexp_t be;
    if (!ARESETn) begin
      held_v = 1'b0;
    end else begin
      if (RVALID) begin
        if (held_v) begin
          check("rdata_stable", RDATA, h_data);
          check("rresp_stable", 32'(RRESP), 32'(h_resp));
          check("rlast_stable", 32'(RLAST), 32'(h_last));
        end
        if (RREADY) begin
          if (rq.size() == 0) check("r_unexpected_beat", 1, 0);
          else begin
            re = rq.pop_front();
            check("rdata", RDATA, re.data);
            check("rresp", 32'(RRESP), 32'(re.resp));
            check("rlast", 32'(RLAST), 32'(re.last));
            check("rid", 32'(RID), 32'(re.id));
          end
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          h_data = RDATA;
          h_resp = RRESP;
          h_last = RLAST;
        end
      end else begin
        held_v = 1'b0;
      end
      if (BVALID && BREADY) begin
        if (bq.size() == 0) check("b_unexpected", 1, 0);
        else begin
          be = bq.pop_front();
          check("bid", 32'(BID), 32'(be.id));
          check("bresp", 32'(BRESP), 32'(be.resp));
        end
      end
    end
  end

  task automatic do_write(input logic [3:0] id, input logic [15:0] addr, input int len,
                          input int size, input int burst, input int wlast_at, input int bdelay);
    bit berr, acc, e;
    logic [15:0] a;
    int n;
    berr = burst_err(len, size, burst);
    acc  = 1'b0;
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, len, size, burst, i);
      e = berr || oob(a) || ((i == wlast_at) != (i == len));
      acc = acc || e;
      if (!oob(a))
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) mdl[int'(a) / 4][8*b +: 8] = wd[i][8*b +: 8];
    end
    bq.push_back('{id, acc ? 2'd2 : 2'd0});
    BREADY  = (bdelay == 0);
    AWID    = id;
    AWADDR  = addr;
    AWLEN   = 8'(len);
    AWSIZE  = 3'(size);
    AWBURST = 2'(burst);
    AWVALID = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
    if (!AWREADY) check("aw_ready_timeout", 0, 1);
    @(posedge ACLK); #1 AWVALID = 1'b0;
    for (int i = 0; i <= len; i++) begin
      WDATA  = wd[i];
      WSTRB  = ws[i];
      WLAST  = (i == wlast_at);
      WVALID = 1'b1;
      n = 0;
      @(negedge ACLK);
      while (!WREADY && n < 50) begin @(negedge ACLK); n++; end
      if (!WREADY) check("w_ready_timeout", 0, 1);
      @(posedge ACLK); #1;
    end
    WVALID = 1'b0;
    WLAST  = 1'b0;
    @(negedge ACLK);
    check("bvalid_latency", 32'(BVALID), 1);
    bcap = BRESP;
    if (bdelay > 0) begin
      repeat (bdelay) begin
        @(posedge ACLK); #1;
        @(negedge ACLK);
        check("bvalid_hold", 32'(BVALID), 1);
        check("bresp_hold", 32'(BRESP), acc ? 2 : 0);
      end
      @(posedge ACLK); #1 BREADY = 1'b1;
      @(negedge ACLK);
    end
    @(posedge ACLK); #1;
  endtask

  // rmode 0: RREADY held high; 1: RREADY toggles every cycle.
  // abort_after > 0: assert reset right after that many beats complete.
  task automatic do_read(input logic [3:0] id, input logic [15:0] addr, input int len,
                         input int size, input int burst, input int rmode, input int abort_after);
    bit berr, e, hs;
    logic [15:0] a;
    int n, beats;
    berr = burst_err(len, size, burst);
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, len, size, burst, i);
      e = berr || oob(a);
      rq.push_back('{id, e ? 32'h0 : mdl[(int'(a) / 4) % DEPTH], e ? 2'd2 : 2'd0, (i == len)});
    end
    ARID    = id;
    ARADDR  = addr;
    ARLEN   = 8'(len);
    ARSIZE  = 3'(size);
    ARBURST = 2'(burst);
    ARVALID = 1'b1;
    RREADY  = (rmode == 0);
    n = 0;
    @(negedge ACLK);
    while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
    if (!ARREADY) check("ar_ready_timeout", 0, 1);
    @(posedge ACLK); #1 ARVALID = 1'b0;
    @(negedge ACLK);
    check("rvalid_latency", 32'(RVALID), 1);
    beats = 0;
    for (int c = 0; c < 200; c++) begin
      hs = RVALID && RREADY;
      if (hs) rcap[beats] = RDATA;
      @(posedge ACLK); #1;
      if (hs) beats++;
      if (rmode == 1) RREADY = !RREADY;
      if (beats > len || (abort_after > 0 && beats == abort_after)) break;
      @(negedge ACLK);
    end
    RREADY = 1'b1;
    if (abort_after == 0) begin
      check("r_beat_count", 32'(beats), 32'(len + 1));
    end else begin
      check("r_beats_before_abort", 32'(beats), 32'(abort_after));
      ARESETn = 1'b0;
      #1;
      check("abort_rvalid", 32'(RVALID), 0);
      check("abort_rlast", 32'(RLAST), 0);
      check("abort_arready", 32'(ARREADY), 0);
      check("abort_rdata", RDATA, 0);
      rq.delete();
      @(negedge ACLK);
      @(negedge ACLK);
      #2 ARESETn = 1'b1;
      #1 check("arready_before_edge", 32'(ARREADY), 0);
      @(posedge ACLK); #1;
      check("arready_after_release", 32'(ARREADY), 1);
      check("awready_after_release", 32'(AWREADY), 1);
    end
  endtask

  task automatic set_beats(input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3, input logic [3:0] s);
    wd[0] = d0; wd[1] = d1; wd[2] = d2; wd[3] = d3;
    for (int i = 0; i < 16; i++) ws[i] = s;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    for (int i = 0; i < 16; i++) begin wd[i] = '0; ws[i] = '0; end

    // Reset state
    #12;
    check("rst_awready", 32'(AWREADY), 0);
    check("rst_wready", 32'(WREADY), 0);
    check("rst_bvalid", 32'(BVALID), 0);
    check("rst_arready", 32'(ARREADY), 0);
    check("rst_rvalid", 32'(RVALID), 0);
    check("rst_rlast", 32'(RLAST), 0);
    check("rst_ids", {BID, RID}, 0);
    check("rst_resps", {BRESP, RRESP}, 0);
    check("rst_rdata", RDATA, 0);
    @(negedge ACLK);
    #2 ARESETn = 1'b1;
    #1 check("rst_arready_pre_edge", 32'(ARREADY), 0);
    @(posedge ACLK); #1;
    check("rst_arready_post_edge", 32'(ARREADY), 1);
    check("rst_awready_post_edge", 32'(AWREADY), 1);

    // Single beat write/read
    set_beats(32'hDEADBEEF, 0, 0, 0, 4'hF);
    do_write(4'd3, 16'h0010, 0, 2, 1, 0, 0);
    check("single_bresp_lit", 32'(bcap), 0);
    do_read(4'd5, 16'h0010, 0, 2, 1, 0, 0);
    check("single_rdata_lit", rcap[0], 32'hDEADBEEF);

    // INCR burst, read back with RREADY toggling
    set_beats(32'd1, 32'd2, 32'd3, 32'd4, 4'hF);
    do_write(4'd1, 16'h0020, 3, 2, 1, 3, 0);
    do_read(4'd2, 16'h0020, 3, 2, 1, 1, 0);
    for (int i = 0; i < 4; i++) check("incr_rdata_lit", rcap[i], 32'(i + 1));

    // WRAP burst
    set_beats(32'hA, 32'hB, 32'hC, 32'hD, 4'hF);
    do_write(4'd4, 16'h0038, 3, 2, 2, 3, 0);
    check("wrap_model_38", mdl[14], 32'hA);
    check("wrap_model_3c", mdl[15], 32'hB);
    check("wrap_model_30", mdl[12], 32'hC);
    check("wrap_model_34", mdl[13], 32'hD);
    do_read(4'd6, 16'h0030, 3, 2, 1, 0, 0);
    check("wrap_rd_30_lit", rcap[0], 32'hC);
    check("wrap_rd_34_lit", rcap[1], 32'hD);
    check("wrap_rd_38_lit", rcap[2], 32'hA);
    check("wrap_rd_3c_lit", rcap[3], 32'hB);
    do_read(4'd7, 16'h0038, 3, 2, 2, 0, 0);

    // Partial strobes, with a stalled write response
    set_beats(32'hDEADBEEF, 0, 0, 0, 4'hF);
    do_write(4'd8, 16'h0040, 0, 2, 1, 0, 0);
    set_beats(32'h00001234, 0, 0, 0, 4'h3);
    do_write(4'd9, 16'h0040, 0, 2, 1, 0, 2);
    do_read(4'd10, 16'h0040, 0, 2, 1, 0, 0);
    check("strobe_rdata_lit", rcap[0], 32'hDEAD1234);

    // Out-of-range address
    set_beats(32'h5A5A5A5A, 0, 0, 0, 4'hF);
    do_write(4'd1, 16'h0000, 0, 2, 1, 0, 0);
    set_beats(32'hFFFFFFFF, 0, 0, 0, 4'hF);
    do_write(4'd2, 16'h0400, 0, 2, 1, 0, 0);
    check("oob_bresp_lit", 32'(bcap), 2);
    do_read(4'd3, 16'h0000, 0, 2, 1, 0, 0);
    check("oob_word0_untouched_lit", rcap[0], 32'h5A5A5A5A);
    do_read(4'd4, 16'h0400, 0, 2, 1, 0, 0);
    check("oob_rdata_lit", rcap[0], 32'h0);

    // Early WLAST
    set_beats(32'd7, 32'd8, 0, 0, 4'hF);
    do_write(4'd5, 16'h0050, 1, 2, 1, 0, 0);
    check("wlast_err_bresp_lit", 32'(bcap), 2);

    // Oversized beat, FIXED, reserved type, illegal WRAP length
    do_read(4'd6, 16'h0020, 0, 3, 1, 0, 0);
    do_read(4'd7, 16'h0020, 2, 2, 0, 0, 0);
    for (int i = 0; i < 3; i++) check("fixed_rdata_lit", rcap[i], 32'd1);
    do_read(4'd8, 16'h0020, 1, 2, 3, 0, 0);
    do_read(4'd9, 16'h0020, 2, 2, 2, 0, 0);

    // Reset during a read burst, then a clean read
    do_read(4'd10, 16'h0020, 3, 2, 1, 0, 2);
    do_read(4'd11, 16'h0020, 3, 2, 1, 0, 0);
    for (int i = 0; i < 4; i++) check("post_reset_rdata_lit", rcap[i], 32'(i + 1));

    repeat (3) @(negedge ACLK);
    check("r_queue_drained", 32'(rq.size()), 0);
    check("b_queue_drained", 32'(bq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_slv_mem.md
AXI_SLV_MEM -- requirements
Module: axi_slv_mem

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16, meaning the AW/AR byte-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the W/R data width in bits (32, 64 or 128).
REQ-003 The block SHALL have parameter ID_WIDTH, default 4, meaning the AWID/BID/ARID/RID width.
REQ-004 The block SHALL have parameter MEM_DEPTH, default 256, meaning the number of DATA_WIDTH-bit storage words.
REQ-005 The block SHALL have the following ports, one per line (name, direction, width, meaning), clock and reset first:
- ACLK  in  1  the single clock; all logic on its rising edge.
- ARESETn  in  1  reset, asynchronous assert, active-low.
- AWID  in  ID_WIDTH  write burst ID.
- AWADDR  in  ADDR_WIDTH  write start byte address.
- AWLEN  in  8  write beats minus 1.
- AWSIZE  in  3  write bytes per beat, log2.
- AWBURST  in  2  write burst type: 0 FIXED, 1 INCR, 2 WRAP.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  DATA_WIDTH  write data.
- WSTRB  in  DATA_WIDTH/8  byte enables.
- WLAST  in  1  last write beat.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BID  out  ID_WIDTH  response ID, equal to the latched AWID.
- BRESP  out  2  write response: 0 OKAY, 2 SLVERR.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- ARID  in  ID_WIDTH  read burst ID.
- ARADDR  in  ADDR_WIDTH  read start byte address.
- ARLEN  in  8  read beats minus 1.
- ARSIZE  in  3  read bytes per beat, log2.
- ARBURST  in  2  read burst type.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RID  out  ID_WIDTH  read ID, equal to the latched ARID.
- RDATA  out  DATA_WIDTH  read data.
- RRESP  out  2  per-beat read response.
- RLAST  out  1  last read beat.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.

Function
REQ-006 Write FSM SHALL have states W_IDLE, W_DATA and W_RESP:
- W_IDLE: AWREADY=1; an AWVALID&&AWREADY handshake latches ID, address, length, size and burst type, clears the beat counter and error flag, and moves to W_DATA.
- W_DATA: WREADY=1; on each WVALID&&WREADY, every byte lane with its WSTRB bit set is written at word index (addr >> log2(DATA_WIDTH/8)); the address then advances.
- W_DATA exit: after beat AWLEN+1 the FSM moves to W_RESP.
- W_RESP: BVALID=1; BID and BRESP are held until BREADY, then the FSM returns to W_IDLE.
REQ-007 Read FSM SHALL have states R_IDLE and R_DATA:
- R_IDLE: ARREADY=1; an ARVALID&&ARREADY handshake latches ID, address, length, size and burst type, registers RDATA from the start word, and moves to R_DATA.
- R_DATA: RVALID=1, so the first RVALID appears 1 cycle after the AR handshake.
- R_DATA beats: on each RVALID&&RREADY the address advances and RDATA/RRESP are re-registered from the next word; RLAST=1 only on beat ARLEN+1; after the last beat the FSM returns to R_IDLE.
- RDATA, RRESP and RLAST SHALL stay stable while RVALID&&!RREADY.
REQ-008 Address advance SHALL depend on burst type:
- FIXED: no change.
- INCR: add (1<<size), modulo 2^ADDR_WIDTH.
- WRAP: add (1<<size) within the aligned region of (len+1)<<size bytes; len must be 1, 3, 7 or 15.
- Reserved burst type 3 SHALL be handled as INCR with an error.
REQ-009 Any of the following SHALL set the error for that burst:
- size > log2(DATA_WIDTH/8);
- WRAP with an illegal len;
- a word index >= MEM_DEPTH;
- WLAST mismatching beat AWLEN+1.
REQ-010 Error responses SHALL be:
- Write: the error is sticky and gives BRESP=2; out-of-range beats write nothing.
- Read: the error is per beat and gives RRESP=2 with RDATA=0 on the failing beat.
REQ-011 The read and write FSMs SHALL run fully independently. A read capturing the same word in the cycle it is written SHALL return the pre-write data.

Reset
REQ-012 While ARESETn is low: both FSMs are idle, and AWREADY, WREADY, BVALID, ARREADY, RVALID and RLAST are 0; BID, BRESP, RID, RRESP and RDATA are 0. AWREADY and ARREADY SHALL go to 1 at the first rising ACLK edge after deassertion.
REQ-013 A reset asserted mid-burst SHALL abort the burst with no response. Memory contents SHALL NOT be reset.

Verification
REQ-014 Write 0x10, len 0, size 2, WDATA 0xDEADBEEF, WSTRB 0xF, BREADY=1 -> BVALID 1 cycle after the W handshake, BRESP=0, BID=AWID; read 0x10 -> RVALID 1 cycle after AR, RDATA 0xDEADBEEF, RLAST=1, RRESP=0.
REQ-015 INCR write, len 3 at 0x20, data 1,2,3,4; read back with RREADY toggling every cycle -> 4 beats 1..4, RLAST on the 4th beat only, RDATA stable during stalls.
REQ-016 WRAP write, len 3, size 2 at 0x38, data A,B,C,D -> words 0x38=A, 0x3C=B, 0x30=C, 0x34=D.
REQ-017 Word 0x40 holds 0xDEADBEEF; write 0x00001234 with WSTRB 0x3 -> read returns 0xDEAD1234.
REQ-018 Write and read at 0x400 (word 256) -> BRESP=2 with memory unchanged; read gives RRESP=2 and RDATA=0.
REQ-019 ARESETn low after beat 2 of a 4-beat read -> RVALID=0 immediately; ARREADY=1 after release; next read completes normally.
